// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 message padder
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;

    localparam logic [WORD_W-1:0] MARKER_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/sha256_last_word_fmt.sv
// rtl/sha256_last_word_fmt.sv - masks unused bytes of the final word and inserts the 0x80 marker
module sha256_last_word_fmt
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    input  logic [2:0]        bytes_i,
    output logic [WORD_W-1:0] word_o,
    output logic              marker_done_o
);

    // Byte p sits at [31-8p -: 8]; the marker lands right after the last valid byte.
    always_comb begin
        word_o = '0;
        for (int p = 0; p < 4; p++) begin
            if (3'(p) < bytes_i) begin
                word_o[WORD_W-1-8*p -: 8] = data_i[WORD_W-1-8*p -: 8];
            end else if (3'(p) == bytes_i) begin
                word_o[WORD_W-1-8*p -: 8] = 8'h80;
            end
        end
    end

    assign marker_done_o = (bytes_i < 3'd4);

endmodule

// File: rtl/sha256_message_padder.sv
// rtl/sha256_message_padder.sv - packs 32-bit message words into padded 512-bit SHA-256 blocks
module sha256_message_padder
    import sha256_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [WORD_W-1:0]               data_i,
    input  logic                            v_i,
    input  logic                            last_i,
    input  logic [2:0]                      bytes_i,
    output logic                            ready_o,
    output logic [WORD_W*BLOCK_WORDS-1:0]   block_o,
    output logic                            v_o,
    input  logic                            ready_i,
    output logic                            first_o,
    output logic                            last_o
);

    state_e            state_q, state_d;
    logic [3:0]        widx_q, widx_d;
    logic [63:0]       len_q, len_d;
    logic              mk_pend_q, mk_pend_d;
    logic              mk_done_q, mk_done_d;
    logic              len_hi_q, len_hi_d;
    logic              len_done_q, len_done_d;
    logic              padded_q, padded_d;
    logic              first_q, first_d;
    logic [WORD_W-1:0] words_q [BLOCK_WORDS];
    logic [WORD_W-1:0] words_d [BLOCK_WORDS];

    logic              in_take;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] fmt_word;
    logic              fmt_done;
    logic [2:0]        bytes_eff;

    assign bytes_eff = (bytes_i > 3'd4) ? 3'd4 : bytes_i;
    assign in_take   = v_i & ready_o;

    sha256_last_word_fmt u_fmt (
        .data_i        (data_i),
        .bytes_i       (bytes_eff),
        .word_o        (fmt_word),
        .marker_done_o (fmt_done)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (in_take && widx_q == 4'd15) state_d = ST_EMIT;
                else if (in_take && last_i)     state_d = ST_PAD;
            end
            ST_PAD: begin
                if (widx_q == 4'd15) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (ready_i) begin
                    if (len_done_q)    state_d = ST_FILL;
                    else if (padded_q) state_d = ST_PAD;
                    else               state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // ready_o is gated by reset so it drops the instant reset asserts.
    always_comb begin
        ready_o = reset_n_i && (state_q == ST_FILL);
        v_o     = (state_q == ST_EMIT);
        first_o = v_o & first_q;
        last_o  = v_o & len_done_q;
    end

    always_comb begin
        widx_d     = widx_q;
        len_d      = len_q;
        mk_pend_d  = mk_pend_q;
        mk_done_d  = mk_done_q;
        len_hi_d   = len_hi_q;
        len_done_d = len_done_q;
        padded_d   = padded_q;
        first_d    = first_q;
        wr_en      = 1'b0;
        wr_data    = data_i;
        case (state_q)
            ST_FILL: begin
                if (in_take) begin
                    wr_en  = 1'b1;
                    widx_d = widx_q + 4'd1;
                    if (last_i) begin
                        wr_data   = fmt_word;
                        len_d     = len_q + {58'b0, bytes_eff, 3'b0};
                        padded_d  = 1'b1;
                        mk_done_d = fmt_done;
                        mk_pend_d = ~fmt_done;
                    end else begin
                        len_d = len_q + 64'd32;
                    end
                end
            end
            ST_PAD: begin
                wr_en  = 1'b1;
                widx_d = widx_q + 4'd1;
                if (mk_pend_q) begin
                    wr_data   = MARKER_WORD;
                    mk_pend_d = 1'b0;
                    mk_done_d = 1'b1;
                end else if (widx_q == 4'd14 && mk_done_q) begin
                    wr_data  = len_q[63:32];
                    len_hi_d = 1'b1;
                end else if (widx_q == 4'd15 && len_hi_q) begin
                    wr_data    = len_q[31:0];
                    len_done_d = 1'b1;
                end else begin
                    wr_data = '0;
                end
            end
            ST_EMIT: begin
                if (ready_i) begin
                    widx_d  = '0;
                    first_d = len_done_q;
                    if (len_done_q) begin
                        len_d      = '0;
                        mk_pend_d  = 1'b0;
                        mk_done_d  = 1'b0;
                        len_hi_d   = 1'b0;
                        len_done_d = 1'b0;
                        padded_d   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            words_d[i] = words_q[i];
        end
        if (wr_en) begin
            words_d[widx_q] = wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            widx_q     <= '0;
            len_q      <= '0;
            mk_pend_q  <= 1'b0;
            mk_done_q  <= 1'b0;
            len_hi_q   <= 1'b0;
            len_done_q <= 1'b0;
            padded_q   <= 1'b0;
            first_q    <= 1'b1;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            widx_q     <= widx_d;
            len_q      <= len_d;
            mk_pend_q  <= mk_pend_d;
            mk_done_q  <= mk_done_d;
            len_hi_q   <= len_hi_d;
            len_done_q <= len_done_d;
            padded_q   <= padded_d;
            first_q    <= first_d;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                words_q[i] <= words_d[i];
            end
        end
    end

    for (genvar w = 0; w < BLOCK_WORDS; w++) begin : g_block
        assign block_o[WORD_W*(BLOCK_WORDS-w)-1 -: WORD_W] = words_q[w];
    end

endmodule

// File: tb/tb_sha256_message_padder.sv
// tb/tb_sha256_message_padder.sv - directed scoreboard bench for sha256_message_padder
module tb_sha256_message_padder;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [31:0]  data_i;
    logic         v_i;
    logic         last_i;
    logic [2:0]   bytes_i;
    logic         ready_o;
    logic [511:0] block_o;
    logic         v_o;
    logic         ready_i;
    logic         first_o;
    logic         last_o;

    always #5 clk_i = ~clk_i;

    sha256_message_padder dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .v_i       (v_i),
        .last_i    (last_i),
        .bytes_i   (bytes_i),
        .ready_o   (ready_o),
        .block_o   (block_o),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .first_o   (first_o),
        .last_o    (last_o)
    );

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    byte unsigned msg_q[$];
    int           total = 0;
    int           bad   = 0;

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Byte-level reference padding: msg || 0x80 || zeros || 64-bit big-endian bit length.
    task automatic model_push();
        byte unsigned    p[$];
        longint unsigned bl;
        exp_t            e;
        int              nb;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = p[b*64+k];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nbytes);
        int n;
        data_i  = d;
        last_i  = l;
        bytes_i = nbytes;
        v_i     = 1'b1;
        n       = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 100) chk1("ready_o_wait", ready_o, 1'b1);
        @(posedge clk_i); #1;
        v_i    = 1'b0;
        last_i = 1'b0;
        data_i = 32'hDEAD_BEEF;
    endtask

    // Unused bytes of the final word carry 0xA5 so masking is exercised.
    task automatic send_msg(input bit push);
        int          n;
        int          nw;
        int          nb;
        logic [31:0] w;
        logic        l;
        n  = msg_q.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        if (push) model_push();
        for (int i = 0; i < nw; i++) begin
            w = 32'hA5A5_A5A5;
            for (int k = 0; k < 4; k++) begin
                if (4*i + k < n) w[31-8*k -: 8] = msg_q[4*i+k];
            end
            l  = (i == nw - 1);
            nb = l ? (n - 4*i) : 4;
            send_word(w, l, 3'(nb));
        end
    endtask

    task automatic collect(input int stall);
        int   n;
        exp_t e;
        ready_i = (stall == 0);
        n = 0;
        while (v_o !== 1'b1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (v_o !== 1'b1) begin
            chk1("v_o_wait", v_o, 1'b1);
            ready_i = 1'b0;
            return;
        end
        if (exp_q.size() == 0) begin
            chk1("unexpected_block", v_o, 1'b0);
            ready_i = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        for (int s = 0; s < stall; s++) begin
            chk1("stall_v_o", v_o, 1'b1);
            chkw("stall_block_o", block_o, e.blk);
            chk1("stall_ready_o", ready_o, 1'b0);
            v_i     = 1'b1;
            data_i  = $urandom;
            last_i  = 1'b1;
            bytes_i = 3'd0;
            @(posedge clk_i); #1;
        end
        v_i     = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        chkw("block_o", block_o, e.blk);
        chk1("first_o", first_o, e.first);
        chk1("last_o", last_o, e.last);
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        last_i    = 1'b0;
        bytes_i   = 3'd0;
        data_i    = 32'h0;
        ready_i   = 1'b0;
        #1;
        chk1("rst_ready_o", ready_o, 1'b0);
        chk1("rst_v_o", v_o, 1'b0);
        chk1("rst_first_o", first_o, 1'b0);
        chk1("rst_last_o", last_o, 1'b0);
        chkw("rst_block_o", block_o, '0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk1("fill_ready_o", ready_o, 1'b1);

        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b1);
        collect(0);

        msg_q = {};
        send_msg(1'b1);
        collect(0);

        msg_q = {};
        for (int i = 0; i < 56; i++) msg_q.push_back(8'(i + 1));
        send_msg(1'b1);
        collect(5);
        collect(0);

        msg_q = {};
        for (int i = 0; i < 55; i++) msg_q.push_back(8'(8'hF0 - i));
        send_msg(1'b1);
        collect(0);

        msg_q = {};
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i * 3 + 7));
        send_msg(1'b1);
        chk1("latency_v_o", v_o, 1'b1);
        chk1("emit_ready_o", ready_o, 1'b0);
        collect(0);
        collect(0);

        msg_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_msg(1'b0);
        repeat (3) @(posedge clk_i);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk1("pad_rst_ready_o", ready_o, 1'b0);
        chk1("pad_rst_v_o", v_o, 1'b0);
        chk1("pad_rst_first_o", first_o, 1'b0);
        chk1("pad_rst_last_o", last_o, 1'b0);
        chkw("pad_rst_block_o", block_o, '0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b1);
        collect(0);

        chkw("scoreboard_empty", 512'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
